multicycle_cu: RTL and testbench

Multi-cycle control unit for the RV32I-subset datapath. It replaces single-cycle opcode decoding with a state machine that sequences FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. Data RAM accesses use a request/acknowledge handshake with a timeout, and branches are resolved from registered ALU status flags. It sits between the instruction memory output and the datapath control inputs (PC, register file, ALU, immediate generator, data RAM).

---
 rtl/cu_pkg.sv | 58 +++++
 rtl/multicycle_cu_branch_eval.sv | 38 +++
 rtl/multicycle_cu.sv | 166 ++++++++++++++++
 tb/tb_multicycle_cu.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and constants for the multi-cycle RV32I-subset control unit.
// Holds the FSM state encoding, opcode/funct3 constants and the instruction classifier.
package cu_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        BRES   = 3'd5,
        TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_S,
        CLS_LW,
        CLS_B,
        CLS_BAD
    } iclass_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_LW = 7'b0000011;

    localparam logic [2:0] F3_LW = 3'b010;
    localparam logic [2:0] F3_SR = 3'b101;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b11;

    // Loads other than lw share the load opcode but are not supported.
    function automatic iclass_t classify(input logic [6:0] opcode, input logic [2:0] funct3);
        iclass_t cls;
        case (opcode)
            OP_R:    cls = CLS_R;
            OP_I:    cls = CLS_I;
            OP_S:    cls = CLS_S;
            OP_B:    cls = CLS_B;
            OP_LW:   cls = (funct3 == F3_LW) ? CLS_LW : CLS_BAD;
            default: cls = CLS_BAD;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_cu_branch_eval.sv
// Branch condition evaluation: maps funct3 and the registered ALU flags {V,C,N,Z}
// to a taken decision and an illegal-encoding indication.
module branch_eval
    import cu_pkg::*;
#(
    parameter int EXT_BRANCH = 1
) (
    input  logic [2:0] funct3,
    input  logic [3:0] flags,
    output logic       taken,
    output logic       illegal
);

    logic z;
    logic n;
    logic c;
    logic v;

    assign {v, c, n, z} = flags;

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = z;
            F3_BNE:  taken = ~z;
            F3_BLT:  taken = n ^ v;
            F3_BGE:  taken = ~(n ^ v);
            F3_BLTU: taken = ~c;
            F3_BGEU: taken = c;
            default: illegal = 1'b1;
        endcase
        // The reduced branch set only keeps beq and bge.
        if (EXT_BRANCH == 0 && funct3 != F3_BEQ && funct3 != F3_BGE)
            illegal = 1'b1;
    end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit sequencing FETCH/DECODE/EXEC/MEM/WB/BRES for the
// RV32I-subset datapath, with a timed RAM handshake and a sticky TRAP state.
module multicycle_cu
    import cu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int EXT_BRANCH  = 1,
    parameter int ALUOP_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic [3:0]         status,
    input  logic               mem_ack,
    output logic               pc_we,
    output logic               ir_we,
    output logic               pcsrc,
    output logic [ALUOP_W-1:0] aluop,
    output logic [1:0]         immsel,
    output logic               wb,
    output logic               alusrc,
    output logic               regrw,
    output logic               memrw,
    output logic               ramen,
    output logic               trap,
    output logic [2:0]         state
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      cur_state;
    logic [31:0] ir;
    logic [3:0]  flags;
    logic [7:0]  wait_cnt;
    iclass_t     cls;
    logic [2:0]  funct3;
    logic        br_taken;
    logic        br_illegal;
    logic [3:0]  ctrl_aluop;
    logic        ctrl_alusrc;
    logic [1:0]  ctrl_immsel;
    logic        unused_ir;

    assign funct3    = ir[14:12];
    assign cls       = classify(ir[6:0], funct3);
    assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

    branch_eval #(
        .EXT_BRANCH(EXT_BRANCH)
    ) u_branch_eval (
        .funct3  (funct3),
        .flags   (flags),
        .taken   (br_taken),
        .illegal (br_illegal)
    );

    // The wait counter only counts MEM cycles without an ack, so an ack on the
    // last allowed cycle still completes the access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state <= FETCH;
            ir        <= '0;
            flags     <= '0;
            wait_cnt  <= '0;
        end else begin
            case (cur_state)
                FETCH: begin
                    ir        <= instr;
                    cur_state <= DECODE;
                end
                DECODE: cur_state <= (cls == CLS_BAD) ? TRAP : EXEC;
                EXEC: begin
                    wait_cnt <= '0;
                    case (cls)
                        CLS_R, CLS_I:  cur_state <= WB;
                        CLS_S, CLS_LW: cur_state <= MEM;
                        CLS_B: begin
                            flags     <= status;
                            cur_state <= BRES;
                        end
                        default: cur_state <= TRAP;
                    endcase
                end
                MEM: begin
                    if (mem_ack)
                        cur_state <= (cls == CLS_LW) ? WB : FETCH;
                    else if (wait_cnt == WAIT_LAST)
                        cur_state <= TRAP;
                    else
                        wait_cnt <= wait_cnt + 8'd1;
                end
                WB:      cur_state <= FETCH;
                BRES:    cur_state <= br_illegal ? TRAP : FETCH;
                default: cur_state <= TRAP;
            endcase
        end
    end

    // ALU/immediate controls depend only on the latched instruction class.
    always_comb begin
        ctrl_aluop  = 4'b0000;
        ctrl_alusrc = 1'b0;
        ctrl_immsel = IMM_I;
        case (cls)
            CLS_R: ctrl_aluop = {ir[30], funct3};
            CLS_I: begin
                ctrl_aluop  = {ir[30] && (funct3 == F3_SR), funct3};
                ctrl_alusrc = 1'b1;
            end
            CLS_S: begin
                ctrl_alusrc = 1'b1;
                ctrl_immsel = IMM_S;
            end
            CLS_LW: ctrl_alusrc = 1'b1;
            CLS_B: begin
                ctrl_aluop  = 4'b1000;
                ctrl_immsel = IMM_B;
            end
            default: ;
        endcase
    end

    // Reset low blanks every output immediately, including an in-flight RAM request.
    always_comb begin
        pc_we  = 1'b0;
        ir_we  = 1'b0;
        pcsrc  = 1'b0;
        aluop  = '0;
        immsel = 2'b00;
        wb     = 1'b0;
        alusrc = 1'b0;
        regrw  = 1'b0;
        memrw  = 1'b0;
        ramen  = 1'b0;
        trap   = 1'b0;
        state  = 3'b000;
        if (reset) begin
            state = cur_state;
            if (cur_state inside {EXEC, MEM, WB, BRES}) begin
                aluop[3:0] = ctrl_aluop;
                alusrc     = ctrl_alusrc;
                immsel     = ctrl_immsel;
            end
            case (cur_state)
                FETCH: ir_we = 1'b1;
                MEM: begin
                    ramen = 1'b1;
                    memrw = (cls == CLS_S);
                    pc_we = (cls == CLS_S) && mem_ack;
                end
                WB: begin
                    regrw = 1'b1;
                    wb    = (cls != CLS_LW);
                    pc_we = 1'b1;
                end
                BRES: begin
                    pc_we = ~br_illegal;
                    pcsrc = br_taken & ~br_illegal;
                end
                TRAP:    trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_cu.sv
// Randomized bench for multicycle_cu: each instruction is expanded into its expected
// per-cycle output trace from the instruction-level rules, then replayed and compared.
module tb_multicycle_cu;

    localparam logic [7:0] ST_PCWE  = 8'h01;
    localparam logic [7:0] ST_IRWE  = 8'h02;
    localparam logic [7:0] ST_PCSRC = 8'h04;
    localparam logic [7:0] ST_WB    = 8'h08;
    localparam logic [7:0] ST_REGRW = 8'h10;
    localparam logic [7:0] ST_MEMRW = 8'h20;
    localparam logic [7:0] ST_RAMEN = 8'h40;
    localparam logic [7:0] ST_TRAP  = 8'h80;

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  st;
        logic        ack;
        logic [17:0] exp;
    } step_t;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [3:0]  status;
    logic        mem_ack;

    logic       pc_we, ir_we, pcsrc, wb, alusrc, regrw, memrw, ramen, trap;
    logic [3:0] aluop;
    logic [1:0] immsel;
    logic [2:0] state;

    logic       nb_pc_we, nb_ir_we, nb_pcsrc, nb_wb, nb_alusrc, nb_regrw, nb_memrw, nb_ramen, nb_trap;
    logic [5:0] nb_aluop;
    logic [1:0] nb_immsel;
    logic [2:0] nb_state;

    logic [31:0] main_vec;
    logic [31:0] nb_vec;

    int    vectors;
    int    miscompares;
    step_t steps[$];

    multicycle_cu dut (
        .clk(clk), .reset(reset), .instr(instr), .status(status), .mem_ack(mem_ack),
        .pc_we(pc_we), .ir_we(ir_we), .pcsrc(pcsrc), .aluop(aluop), .immsel(immsel),
        .wb(wb), .alusrc(alusrc), .regrw(regrw), .memrw(memrw), .ramen(ramen),
        .trap(trap), .state(state)
    );

    multicycle_cu #(.MEM_TIMEOUT(3), .EXT_BRANCH(0), .ALUOP_W(6)) dut_nb (
        .clk(clk), .reset(reset), .instr(instr), .status(status), .mem_ack(mem_ack),
        .pc_we(nb_pc_we), .ir_we(nb_ir_we), .pcsrc(nb_pcsrc), .aluop(nb_aluop),
        .immsel(nb_immsel), .wb(nb_wb), .alusrc(nb_alusrc), .regrw(nb_regrw),
        .memrw(nb_memrw), .ramen(nb_ramen), .trap(nb_trap), .state(nb_state)
    );

    assign main_vec = {14'b0, state, trap, ramen, memrw, regrw, alusrc, wb, immsel,
                       aluop, pcsrc, ir_we, pc_we};
    assign nb_vec   = {12'b0, nb_aluop[5:4], nb_state, nb_trap, nb_ramen, nb_memrw, nb_regrw,
                       nb_alusrc, nb_wb, nb_immsel, nb_aluop[3:0], nb_pcsrc, nb_ir_we, nb_pc_we};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [17:0] vec(input int s, input logic [7:0] strb, input logic asrc,
                                        input logic [1:0] imm, input logic [3:0] op);
        return {3'(s), strb[7], strb[6], strb[5], strb[4], asrc, strb[3], imm, op,
                strb[2], strb[1], strb[0]};
    endfunction

    function automatic void push(input logic [31:0] ins, input logic [3:0] st, input logic ack,
                                 input logic [17:0] e);
        step_t s;
        s.ins = ins;
        s.st  = st;
        s.ack = ack;
        s.exp = e;
        steps.push_back(s);
    endfunction

    function automatic void pushTrap(input int n);
        for (int i = 0; i < n; i++)
            push($urandom, 4'($urandom), 1'($urandom), vec(7, ST_TRAP, 1'b0, 2'b00, 4'h0));
    endfunction

    // Expected trace of one instruction starting at its fetch cycle; lat is the 1-based
    // cycle of its single pc_we pulse (0 when it traps instead).
    task automatic buildSteps(input logic [31:0] ins, input logic [3:0] st, input int k,
                              input bit ext, input int tmo, output bit trapped, output int lat);
        logic [2:0] f3;
        int         kind;
        logic [3:0] op;
        logic       asrc;
        logic [1:0] imm;
        logic       z, n, c, v, taken, legal;
        f3 = ins[14:12];
        trapped = 1'b0;
        lat = 0;
        op = 4'h0;
        asrc = 1'b0;
        imm = 2'b00;
        taken = 1'b0;
        case (ins[6:0])
            7'h33: begin kind = 0; op = {ins[30], f3}; end
            7'h13: begin kind = 1; op = (f3 == 3'd5 && ins[30]) ? 4'hD : {1'b0, f3}; asrc = 1'b1; end
            7'h23: begin kind = 2; asrc = 1'b1; imm = 2'b01; end
            7'h03: begin kind = (f3 == 3'd2) ? 3 : 5; asrc = 1'b1; end
            7'h63: begin kind = 4; op = 4'h8; imm = 2'b11; end
            default: kind = 5;
        endcase
        push(ins, 4'($urandom), 1'($urandom), vec(0, ST_IRWE, 1'b0, 2'b00, 4'h0));
        push($urandom, 4'($urandom), 1'($urandom), vec(1, 8'h00, 1'b0, 2'b00, 4'h0));
        if (kind == 5) begin
            pushTrap(3);
            trapped = 1'b1;
            return;
        end
        push($urandom, (kind == 4) ? st : 4'($urandom), 1'($urandom), vec(2, 8'h00, asrc, imm, op));
        if (kind <= 1) begin
            push($urandom, 4'($urandom), 1'($urandom), vec(4, ST_REGRW | ST_WB | ST_PCWE, asrc, imm, op));
            lat = 4;
        end else if (kind <= 3) begin
            for (int j = 0; j < tmo; j++) begin
                logic a;
                a = (j == k);
                push($urandom, 4'($urandom), a,
                     vec(3, (kind == 2) ? (ST_RAMEN | ST_MEMRW | (a ? ST_PCWE : 8'h00)) : ST_RAMEN,
                         asrc, imm, op));
                if (a) break;
            end
            if (k >= tmo) begin
                pushTrap(3);
                trapped = 1'b1;
            end else if (kind == 2) begin
                lat = 4 + k;
            end else begin
                push($urandom, 4'($urandom), 1'($urandom), vec(4, ST_REGRW | ST_PCWE, asrc, imm, op));
                lat = 5 + k;
            end
        end else begin
            {v, c, n, z} = st;
            legal = ext ? (f3 != 3'd2 && f3 != 3'd3) : (f3 == 3'd0 || f3 == 3'd5);
            case (f3)
                3'd0: taken = z;
                3'd1: taken = !z;
                3'd4: taken = n ^ v;
                3'd5: taken = !(n ^ v);
                3'd6: taken = !c;
                3'd7: taken = c;
                default: taken = 1'b0;
            endcase
            push($urandom, 4'($urandom), 1'($urandom),
                 vec(5, (legal ? ST_PCWE : 8'h00) | ((legal && taken) ? ST_PCSRC : 8'h00), asrc, imm, op));
            if (!legal) begin
                pushTrap(3);
                trapped = 1'b1;
            end else begin
                lat = 4;
            end
        end
    endtask

    task automatic doReset(input int n);
        reset = 1'b0;
        repeat (n) begin
            instr   = $urandom;
            status  = 4'($urandom);
            mem_ack = 1'($urandom);
            @(negedge clk);
            checkOutput("reset_main", main_vec, 32'd0);
            checkOutput("reset_nb", nb_vec, 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    // limit > 0 stops after that many cycles, leaving the instruction unfinished.
    task automatic applyStimulus(input logic [31:0] ins, input logic [3:0] st, input int k,
                                 input bit use_nb, input int limit, output bit trapped);
        int          lat, first, cnt, idx;
        logic [31:0] got;
        buildSteps(ins, st, k, !use_nb, use_nb ? 3 : 15, trapped, lat);
        first = 0;
        cnt = 0;
        idx = 0;
        while (steps.size() > 0 && (limit == 0 || idx < limit)) begin
            step_t s;
            s = steps.pop_front();
            idx++;
            instr   = s.ins;
            status  = s.st;
            mem_ack = s.ack;
            @(negedge clk);
            got = use_nb ? nb_vec : main_vec;
            checkOutput(use_nb ? "nb_cycle" : "cycle", got, {14'b0, s.exp});
            if (got[0]) begin
                cnt++;
                if (first == 0) first = idx;
            end
            @(posedge clk);
            #1;
        end
        steps.delete();
        if (limit == 0) begin
            checkOutput("pcwe_count", 32'(cnt), trapped ? 32'd0 : 32'd1);
            if (!trapped) checkOutput("latency", 32'(first), 32'(lat));
        end
    endtask

    function automatic logic [31:0] randInstr(input bit allow_bad);
        logic [31:0] ins;
        int          r;
        ins = $urandom;
        r = $urandom_range(0, allow_bad ? 19 : 17);
        if (r <= 3)       ins[6:0] = 7'h33;
        else if (r <= 7)  ins[6:0] = 7'h13;
        else if (r <= 10) ins[6:0] = 7'h23;
        else if (r <= 13) begin ins[6:0] = 7'h03; ins[14:12] = 3'd2; end
        else if (r <= 17) ins[6:0] = 7'h63;
        else if (r == 18) ins[6:0] = 7'h03;
        return ins;
    endfunction

    initial begin
        bit          tr;
        int          k;
        logic [31:0] ins;
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        instr = '0;
        status = '0;
        mem_ack = 1'b0;
        doReset(2);

        $display("[TB] directed sequences");
        applyStimulus(32'h002081B3, 4'h0, 0, 1'b0, 0, tr);
        applyStimulus(32'h0000A183, 4'h0, 3, 1'b0, 0, tr);
        applyStimulus(32'h00000063, 4'b0001, 0, 1'b0, 0, tr);
        applyStimulus(32'h00005063, 4'b0010, 0, 1'b0, 0, tr);
        applyStimulus(32'h0020A023, 4'h0, 255, 1'b0, 0, tr);
        doReset(2);
        applyStimulus(32'h0000007F, 4'h0, 0, 1'b0, 0, tr);
        doReset(2);
        applyStimulus(32'h0020A023, 4'h0, 5, 1'b0, 4, tr);
        doReset(1);
        applyStimulus(32'h002081B3, 4'h0, 0, 1'b0, 0, tr);
        applyStimulus(32'h0000A183, 4'h0, 14, 1'b0, 0, tr);
        applyStimulus(32'h0000A183, 4'h0, 15, 1'b0, 0, tr);
        doReset(2);

        $display("[TB] random sequences, full branch set");
        for (int n = 0; n < 200; n++) begin
            ins = randInstr(1'b1);
            k = $urandom_range(0, 4);
            if ($urandom_range(0, 15) == 0) k = $urandom_range(13, 17);
            applyStimulus(ins, 4'($urandom), k, 1'b0, 0, tr);
            if (tr) doReset(2);
        end
        doReset(2);

        $display("[TB] reduced branch set, short timeout");
        applyStimulus(32'h00001063, 4'h0, 0, 1'b1, 0, tr);
        doReset(2);
        applyStimulus(32'h00000063, 4'b0001, 0, 1'b1, 0, tr);
        applyStimulus(32'h00005063, 4'b1010, 0, 1'b1, 0, tr);
        applyStimulus(32'h0000A183, 4'h0, 2, 1'b1, 0, tr);
        applyStimulus(32'h0000A183, 4'h0, 3, 1'b1, 0, tr);
        doReset(2);
        for (int n = 0; n < 60; n++) begin
            ins = randInstr(1'b0);
            applyStimulus(ins, 4'($urandom), $urandom_range(0, 3), 1'b1, 0, tr);
            if (tr) doReset(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
